// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 clock, deframes
// 11-bit frames, folds E0/F0 prefixes into flags and queues key events.
module ps2_scan_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_code,
  output logic       out_break,
  output logic       out_ext,
  output logic       overflow,
  input  logic       ovf_clear,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             filt_q, filt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d, stop_q, stop_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             brk_q, brk_d, ext_q, ext_d;
  logic             ferr_q, ferr_d;
  logic [7:0]       errc_q, errc_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [9:0]       head;
  logic             fall, push, pop, full, wr_en;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stop_d    = stop_q;
    to_cnt_d  = '0;
    brk_d     = brk_q;
    ext_d     = ext_q;
    ferr_d    = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (fall && !dat_s2_q) state_d = RECV;
      end
      RECV: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd8) shift_d = {dat_s2_q, shift_q[7:1]};
          else if (bit_cnt_q == 4'd8) par_d = dat_s2_q;
          else begin
            stop_d  = dat_s2_q;
            state_d = CHECK;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
          brk_d   = 1'b0;
          ext_d   = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        if ((^{shift_q, par_q}) && stop_q) begin
          if (shift_q == 8'hE0) ext_d = 1'b1;
          else if (shift_q == 8'hF0) brk_d = 1'b1;
          else begin
            push  = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end else begin
          ferr_d = 1'b1;
          brk_d  = 1'b0;
          ext_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    errc_d = errc_q;
    if (ferr_d && errc_q != 8'hFF) errc_d = errc_q + 1'b1;
  end

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign wr_en = push & (~full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    ovf_d    = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (ovf_clear) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      to_cnt_q  <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      ferr_q    <= 1'b0;
      errc_q    <= '0;
      ovf_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      clk_s1_q  <= ps2_clk_async;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_data_async;
      dat_s2_q  <= dat_s1_q;
      filt_q    <= filt_d;
      flt_cnt_q <= flt_cnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      to_cnt_q  <= to_cnt_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      ferr_q    <= ferr_d;
      errc_q    <= errc_d;
      ovf_q     <= ovf_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= {brk_q, ext_q, shift_q};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (cnt_q != '0);
  assign out_code  = out_valid ? head[7:0] : '0;
  assign out_ext   = out_valid & head[8];
  assign out_break = out_valid & head[9];
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
  assign err_count = errc_q;

endmodule
